// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//   Game-flow controller for the pong text overlay. It keeps both player
//   scores, selects which text regions are shown, and freezes or releases
//   the ball graphics between points and between games.
//
// Ports
//   clk          pixel clock (single domain)
//   reset        synchronous, active-high reset
//   refresh_tick one-cycle pulse per frame (start of vertical blank)
//   btn_start    start/serve button, level
//   miss1/miss2  one-cycle miss pulses (miss1 -> player 2 scores, miss2 -> player 1)
//   score1/2     binary scores 0..WIN_SCORE
//   text_en      region mask {logo, score1-digit, score2-digit, over}
//   gra_still    1 = ball frozen at centre
//   ball_reset   one-cycle pulse on every entry into PLAY
//   game_over    high while in OVER
//
// Build option
//   PONG_BTN_EDGE_EN : when defined, btn_start is synchronized (2 flops) and
//   edge-detected so each press gives one start pulse. When undefined, the
//   button level is used directly as start.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned DELAY_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       btn_start,
  input  logic       miss1,
  input  logic       miss2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] text_en,
  output logic       gra_still,
  output logic       ball_reset,
  output logic       game_over
);

  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] DELAY = 8'(DELAY_FRAMES);

  typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_t;

  logic start;

`ifdef PONG_BTN_EDGE_EN
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], btn_start};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Rising edge of the synchronized button: one pulse per press.
  assign start = sync_q[1] & ~prev_q;
`else
  assign start = btn_start;
`endif

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic [3:0] text_en_q, text_en_d;
  logic       gra_still_q, gra_still_d;
  logic       ball_reset_q, ball_reset_d;
  logic       game_over_q, game_over_d;

  logic [3:0] s1_inc, s2_inc, s1_new, s2_new;

  // Saturating increments; the game normally ends before saturation matters.
  assign s1_inc = (score1_q < WIN) ? 4'(score1_q + 4'd1) : score1_q;
  assign s2_inc = (score2_q < WIN) ? 4'(score2_q + 4'd1) : score2_q;
  assign s1_new = miss2 ? s1_inc : score1_q;
  assign s2_new = miss1 ? s2_inc : score2_q;

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    // Free-running frame countdown; a load below overrides a same-cycle tick.
    timer_d  = (refresh_tick && timer_q != 8'd0) ? 8'(timer_q - 8'd1) : timer_q;

    case (state_q)
      NEWGAME: if (start) state_d = PLAY;
      PLAY: begin
        if (miss1 || miss2) begin
          score1_d = s1_new;
          score2_d = s2_new;
          timer_d  = DELAY;
          state_d  = (s1_new == WIN || s2_new == WIN) ? OVER : NEWBALL;
        end
      end
      NEWBALL: if (timer_q == 8'd0 && start) state_d = PLAY;
      OVER: begin
        if (timer_q == 8'd0) begin
          state_d  = NEWGAME;
          score1_d = 4'd0;
          score2_d = 4'd0;
        end
      end
      default: state_d = NEWGAME;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // change on the same edge as the state.
    text_en_d   = 4'b0110;
    gra_still_d = 1'b1;
    game_over_d = 1'b0;
    case (state_d)
      NEWGAME: text_en_d = 4'b1110;
      PLAY:    gra_still_d = 1'b0;
      OVER: begin
        text_en_d   = 4'b0111;
        game_over_d = 1'b1;
      end
      default: ;
    endcase
    ball_reset_d = (state_d == PLAY) && (state_q != PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NEWGAME;
      timer_q      <= 8'd0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      text_en_q    <= 4'b1110;
      gra_still_q  <= 1'b1;
      ball_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      text_en_q    <= text_en_d;
      gra_still_q  <= gra_still_d;
      ball_reset_q <= ball_reset_d;
      game_over_q  <= game_over_d;
    end
  end

  assign score1     = score1_q;
  assign score2     = score2_q;
  assign text_en    = text_en_q;
  assign gra_still  = gra_still_q;
  assign ball_reset = ball_reset_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl (default build: level start button).
// Main instance uses WIN_SCORE=9, DELAY_FRAMES=120; a second instance uses
// WIN_SCORE=1, DELAY_FRAMES=0 for the immediate-expiry corner.
module tb_pong_game_ctrl;

  typedef logic [14:0] obs_t; // {score1, score2, text_en, gra_still, ball_reset, game_over}

  typedef struct {
    logic r, t, b, m1, m2;
    obs_t e;
  } vec_t;

  localparam int NG = 0, PL = 1, NB = 2, OV = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tick, btn, m1, m2;
  logic [3:0] s1, s2, te;
  logic gs, br, go;

  logic rst1, tick1, btn1, m1b, m2b;
  logic [3:0] s1b, s2b, teb;
  logic gsb, brb, gob;

  pong_game_ctrl #(.WIN_SCORE(9), .DELAY_FRAMES(120)) dut (
    .clk(clk), .reset(rst), .refresh_tick(tick), .btn_start(btn),
    .miss1(m1), .miss2(m2), .score1(s1), .score2(s2), .text_en(te),
    .gra_still(gs), .ball_reset(br), .game_over(go)
  );

  pong_game_ctrl #(.WIN_SCORE(1), .DELAY_FRAMES(0)) dut1 (
    .clk(clk), .reset(rst1), .refresh_tick(tick1), .btn_start(btn1),
    .miss1(m1b), .miss2(m2b), .score1(s1b), .score2(s2b), .text_en(teb),
    .gra_still(gsb), .ball_reset(brb), .game_over(gob)
  );

  int   total = 0;
  int   bad   = 0;
  int   exs1  = 0;
  int   exs2  = 0;
  obs_t sb_q[$];
  vec_t tbl[7];

  function automatic obs_t ex(int a, int b, int st, bit pulse);
    logic [3:0] t_en;
    t_en = (st == NG) ? 4'b1110 : (st == OV) ? 4'b0111 : 4'b0110;
    return {4'(a), 4'(b), t_en, (st != PL), pulse, (st == OV)};
  endfunction

  task automatic check(input string nm, input obs_t act);
    obs_t e;
    e = sb_q.pop_front();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (s1,s2,te,gs,br,go)", nm, act, e);
    end
  endtask

  task automatic cyc(input string nm, input logic r, t, b, a1, a2, input obs_t e);
    sb_q.push_back(e);
    rst = r; tick = t; btn = b; m1 = a1; m2 = a2;
    @(posedge clk); #1;
    check(nm, {s1, s2, te, gs, br, go});
  endtask

  task automatic cyc1(input string nm, input logic r, b, a1, input obs_t e);
    sb_q.push_back(e);
    rst1 = r; tick1 = 1'b0; btn1 = b; m1b = a1; m2b = 1'b0;
    @(posedge clk); #1;
    check(nm, {s1b, s2b, teb, gsb, brb, gob});
  endtask

  // Miss pulse in PLAY; expected scores follow the scoring rules.
  task automatic miss(input logic a1, a2, t);
    int st;
    if (a2 && exs1 < 9) exs1++;
    if (a1 && exs2 < 9) exs2++;
    st = (exs1 == 9 || exs2 == 9) ? OV : NB;
    cyc("miss", 1'b0, t, 1'b0, a1, a2, ex(exs1, exs2, st, 1'b0));
  endtask

  // 120 frame ticks in NEWBALL, then serve; hold=1 keeps the button down throughout.
  task automatic serve(input bit hold);
    for (int k = 1; k <= 120; k++)
      cyc("nb_wait", 1'b0, 1'b1, hold, 1'b0, 1'b0, ex(exs1, exs2, NB, 1'b0));
    cyc("serve", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(exs1, exs2, PL, 1'b1));
    cyc("play", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(exs1, exs2, PL, 1'b0));
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; btn = 1'b0; m1 = 1'b0; m2 = 1'b0;
    rst1 = 1'b0; tick1 = 1'b0; btn1 = 1'b0; m1b = 1'b0; m2b = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, NG, 1'b0)}; // reset
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, NG, 1'b0)}; // idle
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(0, 0, PL, 1'b1)}; // start
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, PL, 1'b0)}; // pulse ends
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(0, 0, PL, 1'b0)}; // btn ignored in PLAY
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ex(1, 0, NB, 1'b0)}; // miss2 with tick: load wins
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ex(1, 0, NB, 1'b0)}; // miss ignored in NEWBALL

    @(posedge clk); #1;
    for (int i = 0; i < 7; i++)
      cyc($sformatf("vec%0d", i), tbl[i].r, tbl[i].t, tbl[i].b, tbl[i].m1, tbl[i].m2, tbl[i].e);
    exs1 = 1;

    // Held button: exactly 120 ticks before PLAY resumes.
    serve(1'b1);

    // Player 1 up to 8, then the winning point.
    for (int s = 2; s <= 8; s++) begin
      miss(1'b0, 1'b1, 1'b0);
      serve(1'b0);
    end
    miss(1'b0, 1'b1, 1'b0);

    // OVER: button ignored, 120 ticks, then NEWGAME with scores cleared.
    for (int k = 1; k <= 120; k++)
      cyc("over_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ex(9, 0, OV, 1'b0));
    exs1 = 0; exs2 = 0;
    cyc("over_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, NG, 1'b0));
    cyc("restart", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(0, 0, PL, 1'b1));
    cyc("play", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, PL, 1'b0));

    // Build 3/4, then a simultaneous miss.
    for (int k = 0; k < 3; k++) begin miss(1'b0, 1'b1, 1'b0); serve(1'b0); end
    for (int k = 0; k < 4; k++) begin miss(1'b1, 1'b0, 1'b0); serve(1'b0); end
    miss(1'b1, 1'b1, 1'b0);
    cyc("nb_ignore", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ex(4, 5, NB, 1'b0));
    serve(1'b0);

    // Player 2 wins; misses in OVER ignored; reset at tick 50.
    for (int k = 0; k < 3; k++) begin miss(1'b1, 1'b0, 1'b0); serve(1'b0); end
    miss(1'b1, 1'b0, 1'b0);
    cyc("ov_ignore", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ex(4, 9, OV, 1'b0));
    for (int k = 1; k <= 50; k++)
      cyc("ov_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ex(4, 9, OV, 1'b0));
    cyc("mid_reset", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ex(0, 0, NG, 1'b0));
    cyc("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ex(0, 0, NG, 1'b0));
    cyc("post_start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ex(0, 0, PL, 1'b1));

    // WIN_SCORE=1, DELAY_FRAMES=0 instance.
    cyc1("d0_reset", 1'b1, 1'b0, 1'b0, ex(0, 0, NG, 1'b0));
    cyc1("d0_start", 1'b0, 1'b1, 1'b0, ex(0, 0, PL, 1'b1));
    cyc1("d0_miss", 1'b0, 1'b0, 1'b1, ex(0, 1, OV, 1'b0));
    cyc1("d0_expire", 1'b0, 1'b0, 1'b0, ex(0, 0, NG, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
